inst_fetch: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. It samples the current PC,

---
 rtl/inst_fetch.sv | 172 +++++++++++++++++
 tb/tb_inst_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: IF stage between pc_reg and the IF/ID latch; fetches one word per PC over req/ack,
// holds it for IF/ID and squashes on EX redirects. Define ICACHE_EN for a direct-mapped I-cache.
module inst_fetch #(
  parameter int ADDR_W       = 32,
  parameter int INST_W       = 32,
  parameter int ICACHE_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [5:0]        stall,
  input  logic              ifjump,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_inst_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic              stallreq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic                mem_req_q,  mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   if_pc_q,    if_pc_d;
  logic [INST_W-1:0]   if_inst_q,  if_inst_d;
  logic                if_valid_q, if_valid_d;
  logic                discard_q,  discard_d;

  logic                cache_hit;
  logic [INST_W-1:0]   hit_inst;

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [ICACHE_LINES-1:0] line_vld_q, line_vld_d;
  logic [TAG_W-1:0]        line_tag_q [ICACHE_LINES];
  logic [INST_W-1:0]       line_dat_q [ICACHE_LINES];
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        wr_idx;
  logic                    cache_fill;

  assign rd_idx    = pc_i[2 +: IDX_W];
  assign wr_idx    = mem_addr_q[2 +: IDX_W];
  assign cache_hit = line_vld_q[rd_idx] && (line_tag_q[rd_idx] == pc_i[ADDR_W-1 -: TAG_W]);
  assign hit_inst  = line_dat_q[rd_idx];
  // Squashed fetches still fill: the word is correct, only its delivery was unwanted.
  assign cache_fill = rdy && (state_q == WAIT) && mem_ack_i;

  always_comb begin
    line_vld_d = line_vld_q;
    if (cache_fill) begin
      line_vld_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_vld_q <= '0;
    end else begin
      line_vld_q <= line_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_fill) begin
      line_tag_q[wr_idx] <= mem_addr_q[ADDR_W-1 -: TAG_W];
      line_dat_q[wr_idx] <= mem_inst_i;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (ICACHE_LINES > 0);
  assign cache_hit  = 1'b0;
  assign hit_inst   = '0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    discard_d  = discard_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (ifjump) begin
            if_valid_d = 1'b0;
          end else if (cache_hit) begin
            if_pc_d    = pc_i;
            if_inst_d  = hit_inst;
            if_valid_d = 1'b1;
            state_d    = DONE;
          end else begin
            mem_addr_d = pc_i;
            mem_req_d  = 1'b1;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (mem_ack_i) begin
            mem_req_d = 1'b0;
            if (discard_q || ifjump) begin
              discard_d = 1'b0;
              state_d   = IDLE;
            end else begin
              if_pc_d    = mem_addr_q;
              if_inst_d  = mem_inst_i;
              if_valid_d = 1'b1;
              state_d    = DONE;
            end
          end else if (ifjump) begin
            // The memory transaction cannot be withdrawn; remember to drop its ack.
            discard_d = 1'b1;
          end
        end
        DONE: begin
          if (ifjump || !stall[1]) begin
            if_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      discard_q  <= discard_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;
  assign if_valid_o = if_valid_q;
  assign stallreq_o = (state_q != DONE);

  // Only stall[1] concerns this stage; the other stall bits belong to other stages.
  logic unused_ok;
  assign unused_ok = ^{stall[5:2], stall[0]};

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic, with a scoreboard that
// predicts the delivered (pc, inst) stream from the program-order/redirect rules.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [31:0] pc_i = '0;
  logic [5:0]  stall = '0;
  logic        ifjump = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_inst_i = '0;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        stallreq_o;

  int checks = 0;
  int failures = 0;
  int consumed = 0;

  logic [31:0] jump_tgt = '0;
  logic [31:0] pc_nxt = '0;
  logic        resp_rand = 1'b0;
  int          resp_dly = 2;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(32), .INST_W(32), .ICACHE_LINES(64)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .stall(stall), .ifjump(ifjump),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_inst_i(mem_inst_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .if_valid_o(if_valid_o), .stallreq_o(stallreq_o)
  );

  // Instruction memory contents: address 0 holds 0x00500093 (addi x1,x0,5).
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'h00500093 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!if_valid_o && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (!if_valid_o) begin
      failures++;
      $display("FAIL %s: if_valid_o still 0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (!mem_req_o && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (!mem_req_o) begin
      failures++;
      $display("FAIL %s: mem_req_o still 0 after %0d cycles, required 1", name, budget);
    end
  endtask

  // Memory controller: acks a pending request after a delay, one-cycle pulse.
  int          wait_cnt = 0;
  int          rnd_dly = 0;
  always begin
    int lim;
    @(posedge clk);
    #1;
    lim = resp_rand ? rnd_dly : resp_dly;
    if (rst) begin
      mem_ack_i = 1'b0;
      wait_cnt  = 0;
    end else if (mem_ack_i) begin
      mem_ack_i  = 1'b0;
      mem_inst_i = $urandom;
    end else if (mem_req_o) begin
      if (wait_cnt >= lim) begin
        mem_ack_i  = 1'b1;
        mem_inst_i = inst_of(mem_addr_o);
        wait_cnt   = 0;
        rnd_dly    = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end
  end

  // pc_reg stand-in: applies the next PC computed by the monitor for this edge.
  always begin
    @(posedge clk);
    #1;
    pc_i = pc_nxt;
  end

  // Monitor and scoreboard. The expected program-order stream restarts at 0 on reset
  // and at the target on every accepted redirect; each consumption pops one entry.
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      pc_nxt   = '0;
      prev_req = 1'b0;
    end else begin
      chk("stallreq_vs_valid", {31'b0, stallreq_o}, {31'b0, !if_valid_o});
      if (prev_req && mem_req_o) chk("addr_stable", mem_addr_o, prev_addr);
      prev_req  = mem_req_o;
      prev_addr = mem_addr_o;
      pc_nxt = pc_i;
      if (rdy) begin
        if (ifjump) begin
          exp_q.delete();
          for (int i = 0; i < 8; i++) exp_q.push_back(jump_tgt + 32'(i * 4));
          pc_nxt = jump_tgt;
        end else begin
          if (if_valid_o && !stall[1]) begin
            e = exp_q.pop_front();
            consumed++;
            chk("deliver_pc", if_pc_o, e);
            chk("deliver_inst", if_inst_o, inst_of(e));
            exp_q.push_back(exp_q[$] + 32'd4);
          end
          if (!stallreq_o && !stall[0]) pc_nxt = pc_i + 32'd4;
        end
      end
    end
  end

  initial begin
    int n;
    logic saw_valid;
    logic s1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_stallreq", {31'b0, stallreq_o}, 32'd1);
    rst = 1'b0;

    // First fetch at PC 0 with a delayed ack.
    wait_valid("t2_first_valid", 20);
    chk("t2_pc", if_pc_o, 32'h0);
    chk("t2_inst", if_inst_o, 32'h00500093);
    chk("t2_stallreq_low", {31'b0, stallreq_o}, 32'd0);
    resp_dly = 1;
    cyc();
    chk("t2_stallreq_one_cycle", {31'b0, stallreq_o}, 32'd1);
    wait_req("t2_next_req", 10);
    chk("t2_next_addr", mem_addr_o, 32'h4);

    // Redirect while the fetch of 0x8 is outstanding.
    wait_valid("t3_valid_0x4", 20);
    cyc();
    wait_req("t3_req_0x8", 10);
    chk("t3_req_addr", mem_addr_o, 32'h8);
    ifjump   = 1'b1;
    jump_tgt = 32'h100;
    cyc();
    ifjump    = 1'b0;
    saw_valid = if_valid_o;
    n = 0;
    do begin
      cyc();
      saw_valid |= if_valid_o;
      n++;
    end while (!(mem_req_o && mem_addr_o != 32'h8) && n < 10);
    chk("t3_dropped_valid", {31'b0, saw_valid}, 32'd0);
    chk("t3_redirect_addr", mem_addr_o, 32'h100);

    // IF/ID stalled for three cycles while an instruction is presented.
    stall = 6'b000011;
    wait_valid("t4_valid", 20);
    resp_dly = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_hold_pc", if_pc_o, 32'h100);
      chk("t4_hold_inst", if_inst_o, inst_of(32'h100));
      chk("t4_hold_valid", {31'b0, if_valid_o}, 32'd1);
    end
    stall = 6'b000000;
    cyc();
    chk("t4_release_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t4_release_stallreq", {31'b0, stallreq_o}, 32'd1);

    // Global freeze while an ack pulse arrives.
    wait_req("t5_req", 10);
    chk("t5_req_addr", mem_addr_o, 32'h104);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_frozen_req", {31'b0, mem_req_o}, 32'd1);
      chk("t5_frozen_valid", {31'b0, if_valid_o}, 32'd0);
    end
    chk("t5_frozen_addr", mem_addr_o, 32'h104);
    rdy = 1'b1;
    wait_valid("t5_resume_valid", 20);
    chk("t5_resume_pc", if_pc_o, 32'h104);

    // Asynchronous reset in the middle of an outstanding request.
    cyc();
    wait_req("t1_req", 10);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_req", {31'b0, mem_req_o}, 32'd0);
    chk("t1_addr", mem_addr_o, 32'd0);
    chk("t1_pc", if_pc_o, 32'd0);
    chk("t1_inst", if_inst_o, 32'd0);
    chk("t1_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t1_stallreq", {31'b0, stallreq_o}, 32'd1);
    repeat (2) cyc();

`ifdef ICACHE_EN
    // Loop 0x10 -> 0x14 -> 0x10: the revisit must hit without a memory request.
    ifjump   = 1'b1;
    jump_tgt = 32'h10;
    rst = 1'b0;
    cyc();
    ifjump = 1'b0;
    n = 0;
    while (!(if_valid_o && if_pc_o == 32'h14) && n < 40) begin
      cyc();
      n++;
    end
    chk("t6_reach_0x14", if_pc_o, 32'h14);
    ifjump   = 1'b1;
    jump_tgt = 32'h10;
    cyc();
    ifjump = 1'b0;
    chk("t6_idle_req", {31'b0, mem_req_o}, 32'd0);
    cyc();
    chk("t6_hit_req", {31'b0, mem_req_o}, 32'd0);
    chk("t6_hit_valid", {31'b0, if_valid_o}, 32'd1);
    chk("t6_hit_pc", if_pc_o, 32'h10);
    chk("t6_hit_inst", if_inst_o, inst_of(32'h10));
`else
    rst = 1'b0;
`endif

    // Randomized traffic: freezes, IF/ID stalls, redirects and variable memory latency.
    resp_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      s1    = ($urandom_range(0, 4) == 0);
      stall = {4'b0000, s1, s1};
      if ($urandom_range(0, 19) == 0) begin
        ifjump   = 1'b1;
        jump_tgt = 32'($urandom_range(0, 4095));
`ifdef ICACHE_EN
        jump_tgt[1:0] = 2'b00;
`endif
      end else begin
        ifjump = 1'b0;
      end
      cyc();
    end
    rdy    = 1'b1;
    stall  = 6'b000000;
    ifjump = 1'b0;
    repeat (40) cyc();
    chk("progress", {31'b0, (consumed > 100)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
